cpu_seq_ctrl: RTL

- Multi-cycle control sequencer for the RV32I core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- It drives the enables for the IR, PC, register file and RAM, and the writeback mux select.
- It handshakes with ROM and RAM using req/ack, so wait-state memories are supported.
- It sits beside the datapath. Its inputs are the decoded opcode/funct3 fields and the comparator result.

---
 rtl/cpu_pkg.sv | 59 +++++
 rtl/mem_wait_timer.sv | 34 +++
 rtl/cpu_seq_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg : opcode, state, writeback-select and fault encodings for the
//           RV32I multi-cycle sequencer.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd7;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] FAULT_NONE    = 2'd0;
  localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
  localparam logic [1:0] FAULT_ROM_TO  = 2'd2;
  localparam logic [1:0] FAULT_RAM_TO  = 2'd3;

  typedef enum logic [2:0] {
    CL_ALU     = 3'd0,
    CL_LOAD    = 3'd1,
    CL_STORE   = 3'd2,
    CL_BRANCH  = 3'd3,
    CL_JUMP    = 3'd4,
    CL_ILLEGAL = 3'd5
  } instr_class_t;

  function automatic instr_class_t classify(input logic [6:0] op);
    instr_class_t cls;
    case (op)
      OP_REG, OP_IMM, OP_LUI, OP_AUIPC: cls = CL_ALU;
      OP_LOAD:                          cls = CL_LOAD;
      OP_STORE:                         cls = CL_STORE;
      OP_BRANCH:                        cls = CL_BRANCH;
      OP_JAL, OP_JALR:                  cls = CL_JUMP;
      default:                          cls = CL_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wait_timer.sv
// ----------------------------------------------------------------------------
// mem_wait_timer : counts cycles a memory request waits without ack and flags
//                  the cycle on which the count reaches TIMEOUT.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [15:0] c_LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= 16'd0;
    end else if (i_en) begin
      r_count <= r_count + 16'd1;
    end
  end

  // Expires on the waiting cycle whose increment would bring the count to TIMEOUT.
  assign o_expire = i_en && (r_count == c_LIMIT);

endmodule

`default_nettype wire

// File: rtl/cpu_seq_ctrl.sv
// ----------------------------------------------------------------------------
// cpu_seq_ctrl : multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with
//                req/ack memory handshakes and wait timeout.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cpu_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int TIMEOUT   = 255,
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 cmp_q,
  input  logic                 rom_ack,
  input  logic                 ram_ack,
  output logic                 rom_req,
  output logic                 ram_req,
  output logic                 ram_wen,
  output logic                 ir_load,
  output logic                 pc_inc,
  output logic                 pc_load,
  output logic                 reg_wen,
  output logic [1:0]           wb_sel,
  output logic [1:0]           fault,
  output logic [INSTRET_W-1:0] instret,
  output logic [2:0]           state
);

  logic [2:0]           r_state;
  instr_class_t         r_class;
  logic [1:0]           r_fault;
  logic [1:0]           r_wb_sel;
  logic [INSTRET_W-1:0] r_instret;

  logic [2:0] w_next;
  logic       w_ir_load;
  logic       w_pc_inc;
  logic       w_pc_load;
  logic       w_reg_wen;
  logic       w_retire;
  logic       w_fault_set;
  logic [1:0] w_fault_code;
  logic       w_wait;
  logic       w_clear;
  logic       w_expire;
  logic       w_unused;

  assign w_unused = ^funct3;

  assign w_wait  = ((r_state == S_FETCH) && !rom_ack) || ((r_state == S_MEM) && !ram_ack);
  assign w_clear = (w_next != r_state) && ((w_next == S_FETCH) || (w_next == S_MEM));

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_clear),
    .i_en     (w_wait),
    .o_expire (w_expire)
  );

  always_comb begin
    w_next       = r_state;
    w_ir_load    = 1'b0;
    w_pc_inc     = 1'b0;
    w_pc_load    = 1'b0;
    w_reg_wen    = 1'b0;
    w_retire     = 1'b0;
    w_fault_set  = 1'b0;
    w_fault_code = FAULT_NONE;
    case (r_state)
      S_FETCH: begin
        if (rom_ack) begin
          w_ir_load = 1'b1;
          w_next    = S_DECODE;
        end else if (w_expire) begin
          w_next       = S_TRAP;
          w_fault_set  = 1'b1;
          w_fault_code = FAULT_ROM_TO;
        end
      end
      S_DECODE: begin
        if (classify(opcode) == CL_ILLEGAL) begin
          w_next       = S_TRAP;
          w_fault_set  = 1'b1;
          w_fault_code = FAULT_ILLEGAL;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        case (r_class)
          CL_BRANCH: begin
            w_pc_load = cmp_q;
            w_pc_inc  = !cmp_q;
            w_retire  = 1'b1;
            w_next    = S_FETCH;
          end
          CL_LOAD, CL_STORE: w_next = S_MEM;
          default:           w_next = S_WB;
        endcase
      end
      S_MEM: begin
        if (ram_ack) begin
          if (r_class == CL_STORE) begin
            w_pc_inc = 1'b1;
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end else if (w_expire) begin
          w_next       = S_TRAP;
          w_fault_set  = 1'b1;
          w_fault_code = FAULT_RAM_TO;
        end
      end
      S_WB: begin
        w_reg_wen = 1'b1;
        w_pc_load = (r_class == CL_JUMP);
        w_pc_inc  = (r_class != CL_JUMP);
        w_retire  = 1'b1;
        w_next    = S_FETCH;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_class   <= CL_ALU;
      r_fault   <= FAULT_NONE;
      r_wb_sel  <= WB_ALU;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_class <= classify(opcode);
      end
      if (w_fault_set) begin
        r_fault <= w_fault_code;
      end
      // Select is registered on entry to WB so it is valid there and holds afterwards.
      if ((w_next == S_WB) && (r_state != S_WB)) begin
        case (r_class)
          CL_LOAD: r_wb_sel <= WB_MEM;
          CL_JUMP: r_wb_sel <= WB_PC4;
          default: r_wb_sel <= WB_ALU;
        endcase
      end
      if (w_retire) begin
        r_instret <= r_instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign rom_req = (r_state == S_FETCH);
  assign ram_req = (r_state == S_MEM);
  assign ram_wen = (r_state == S_MEM) && (r_class == CL_STORE);
  assign ir_load = w_ir_load & ~rst;
  assign pc_inc  = w_pc_inc  & ~rst;
  assign pc_load = w_pc_load & ~rst;
  assign reg_wen = w_reg_wen & ~rst;
  assign wb_sel  = r_wb_sel;
  assign fault   = r_fault;
  assign instret = r_instret;
  assign state   = r_state;

endmodule

`default_nettype wire
